oai4_stream: RTL and testbench

OAI4_STREAM -- requirements
Module: oai4_stream

---
 rtl/oai4_pkg.sv | 22 ++
 rtl/oai4_core.sv | 22 ++
 rtl/oai4_stream.sv | 137 +++++++++++++
 tb/tb_oai4_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/oai4_pkg.sv
// Shared definitions for the OAI4 streaming block: buffer state encoding,
// default widths and the single-bit OR-AND-INVERT helper.
package oai4_pkg;

  // Default operand/result width and transfer-counter width.
  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 16;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // OR-AND-INVERT 2-2 on a single bit.
  function automatic logic oai22_bit(input logic a, input logic b,
                                     input logic c, input logic d);
    return ~((a | b) & (c | d));
  endfunction

endpackage

// File: rtl/oai4_core.sv
// Combinational per-bit OR-AND-INVERT 2-2 over W-bit operand vectors.
module oai4_core
  import oai4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);

  // Apply the single-bit OAI function independently to each bit position.
  always_comb begin
    y = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      y[i] = oai22_bit(a[i], b[i], c[i], d[i]);
    end
  end

endmodule

// File: rtl/oai4_stream.sv
// OAI4 streaming block: operands are turned into an OAI 2-2 result by
// oai4_core and queued in a 2-entry in-order buffer behind a valid/ready
// handshake. in_ready and out_valid are flops, so no combinational path
// runs from out_ready to in_ready.
// Optional feature: define OAI4_STREAM_CNT_EN to build the done_cnt
// transfer counter; otherwise done_cnt is tied to zero.
module oai4_stream
  import oai4_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] done_cnt
);

  logic [W-1:0] w_res;
  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [W-1:0] w_head_nxt;
  logic [W-1:0] w_tail_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         w_in_fire;
  logic         w_out_fire;

  oai4_core #(.W(W)) u_core (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .y (w_res)
  );

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_head;

  // Next buffer state and contents from the current occupancy and handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ONE;
          w_head_nxt  = w_res;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Head leaves and the new result takes its place.
          w_state_nxt = ONE;
          w_head_nxt  = w_res;
        end else if (w_in_fire) begin
          w_state_nxt = FULL;
          w_tail_nxt  = w_res;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
          w_head_nxt  = {W{1'b0}};
        end else begin
          w_state_nxt = ONE;
        end
      end
      FULL: begin
        // in_ready is low here, so operands are never captured.
        if (w_out_fire) begin
          w_state_nxt = ONE;
          w_head_nxt  = r_tail;
          w_tail_nxt  = {W{1'b0}};
        end else begin
          w_state_nxt = FULL;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_head_nxt  = {W{1'b0}};
        w_tail_nxt  = {W{1'b0}};
      end
    endcase
  end

  // State, buffer and handshake flags; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_head      <= {W{1'b0}};
      r_tail      <= {W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt == ONE) || (w_state_nxt == FULL);
    end
  end

`ifdef OAI4_STREAM_CNT_EN
  logic [CNT_W-1:0] r_done_cnt;

  // Count completed output transfers, wrapping naturally at the width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done_cnt <= {CNT_W{1'b0}};
    end else if (w_out_fire) begin
      r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_done_cnt <= r_done_cnt;
    end
  end

  assign done_cnt = r_done_cnt;
`else
  assign done_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_oai4_stream.sv
// Directed self-checking bench for oai4_stream (W=4, CNT_W=4).
// A small queue model tracks buffer contents; result values come from a
// hand-computed vector table.
module tb_oai4_stream;

`ifdef OAI4_STREAM_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b, c, d;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] done_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  logic [3:0] q[$];
  logic [3:0] cur_exp;

  // Hand-computed vectors: {a, b, c, d, expected y}
  logic [19:0] tbl [8] = '{
    {4'b0000, 4'b0011, 4'b0101, 4'b0000, 4'b1110},
    {4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000},
    {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111},
    {4'b1010, 4'b0100, 4'b0011, 4'b1000, 4'b0101},
    {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111},
    {4'b1100, 4'b0000, 4'b0110, 4'b0001, 4'b1011},
    {4'b0110, 4'b1001, 4'b1010, 4'b0101, 4'b0000},
    {4'b1000, 4'b0001, 4'b1001, 4'b0000, 4'b0110}
  };

  oai4_stream #(.W(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_done();
    return CNT_EN ? 4'(n_done) : 4'd0;
  endfunction

  task automatic set_vec(input int idx, input logic vld);
    logic [19:0] e;
    e        = tbl[idx];
    a        = e[19:16];
    b        = e[15:12];
    c        = e[11:8];
    d        = e[7:4];
    cur_exp  = e[3:0];
    in_valid = vld;
  endtask

  // One clock: predict handshakes, update the model, then check outputs.
  task automatic tick();
    bit in_f, out_f;
    in_f  = in_valid && (q.size() < 2);
    out_f = out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      n_done = 0;
    end else begin
      if (out_f) begin
        void'(q.pop_front());
        n_done++;
      end
      if (in_f) q.push_back(cur_exp);
    end
    #1;
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("in_ready", in_ready, q.size() < 2);
    check_eq("done_cnt", done_cnt, exp_done());
    if (q.size() > 0) check_eq("y_head", y, q[0]);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    set_vec(0, 1'b0);

    // Reset / idle
    tick(); tick();
    rst = 1'b0;
    tick();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_y", y, 0);
    check_eq("rst_done", done_cnt, 0);

    // Single op
    out_ready = 1'b1;
    set_vec(0, 1'b1);
    tick();
    check_eq("single_y", y, 4'b1110);
    check_eq("single_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    check_eq("single_done", done_cnt, CNT_EN ? 1 : 0);
    tick();  // out_ready while empty: no effect

    // Backpressure
    out_ready = 1'b0;
    set_vec(1, 1'b1); tick();
    set_vec(2, 1'b1); tick();
    check_eq("bp_full_in_ready", in_ready, 0);
    set_vec(3, 1'b1); tick();
    check_eq("bp_stall_y0", y, 4'b0000);
    tick();
    check_eq("bp_stall_y1", y, 4'b0000);
    out_ready = 1'b1;
    tick();
    check_eq("bp_second_y", y, 4'b1111);
    tick();
    check_eq("bp_third_y", y, 4'b0101);
    in_valid = 1'b0;
    tick();
    check_eq("bp_drained", out_valid, 0);
    check_eq("bp_done", done_cnt, CNT_EN ? 4 : 0);

    // Simultaneous in/out while ONE
    out_ready = 1'b0;
    set_vec(4, 1'b1); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_vec((5 + i) % 8, 1'b1);
      tick();
      check_eq("sim_in_ready", in_ready, 1);
      check_eq("sim_out_valid", out_valid, 1);
    end
    check_eq("sim_last_y", y, 4'b0000);
    check_eq("sim_done", done_cnt, CNT_EN ? 9 : 0);
    in_valid = 1'b0;
    tick();
    check_eq("sim_drain_done", done_cnt, CNT_EN ? 10 : 0);

    // Mid-op reset in FULL
    out_ready = 1'b0;
    set_vec(6, 1'b1); tick();
    set_vec(7, 1'b1); tick();
    check_eq("mid_full", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_out_valid", out_valid, 0);
    check_eq("mid_in_ready", in_ready, 1);
    check_eq("mid_y", y, 0);
    check_eq("mid_done", done_cnt, 0);
    tick();
    check_eq("mid_no_emit", out_valid, 0);

    // Counter wrap: 17 transfers with a 4-bit counter
    out_ready = 1'b0;
    set_vec(0, 1'b1); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_vec(i % 8, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("wrap_done", done_cnt, CNT_EN ? 1 : 0);
    check_eq("wrap_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
